alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states,
// instruction field positions and small decode helpers.
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int INSTR_W  = 16;
    localparam int RF_DEPTH = 4;
    localparam int RF_AW    = 2;

    // Instruction field positions (ALU and LI formats share rd)
    localparam int FMT_BIT = 15;
    localparam int OP_MSB  = 14;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 6;
    localparam int OFF_MSB = 5;
    localparam int OFF_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_BEQ = 3'b110,
        OP_BNE = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic is_branch(input alu_op_e op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic [DATA_W-1:0] sext_off(input logic [OFF_MSB-OFF_LSB:0] off);
        return {{(DATA_W - (OFF_MSB - OFF_LSB + 1)){off[OFF_MSB-OFF_LSB]}}, off};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational operand reads, one debug read,
// one synchronous write port, all entries cleared by asynchronous reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RF_AW-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RF_AW-1:0]  ra_addr,
    input  logic [RF_AW-1:0]  rb_addr,
    input  logic [RF_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_reg [RF_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign ra_data  = regs_reg[ra_addr];
    assign rb_data  = regs_reg[rb_addr];
    assign dbg_data = regs_reg[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external combinational ALU and
// retires it: register write-back, pc update and sticky add overflow.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [2:0]         alu_sel,
    input  logic [DATA_W-1:0]  alu_f,
    input  logic               alu_ovf,
    input  logic               alu_take_branch,
    output logic [DATA_W-1:0]  pc,
    output logic               ovf_flag,
    input  logic               ovf_clr,
    input  logic [RF_AW-1:0]   dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e              state_reg;
    logic [INSTR_W-1:0]  ir_reg;
    logic [DATA_W-1:0]   pc_reg;
    logic                ovf_reg;
    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    alu_op_e             alu_sel_reg;

    logic                accept;
    logic                in_is_li;
    alu_op_e             in_op;
    logic [DATA_W-1:0]   ra_data;
    logic [DATA_W-1:0]   rb_data;

    logic                ir_is_li;
    alu_op_e             ir_op;
    logic                ir_branch;
    logic                rf_we;
    logic [RF_AW-1:0]    rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   pc_next;

    assign instr_ready = (state_reg == ST_IDLE);
    assign accept      = instr_valid && instr_ready;

    // Operands are read from the incoming word so they can be registered on the accept edge
    assign in_is_li = instr[FMT_BIT];
    assign in_op    = alu_op_e'(instr[OP_MSB:OP_LSB]);

    assign ir_is_li  = ir_reg[FMT_BIT];
    assign ir_op     = alu_op_e'(ir_reg[OP_MSB:OP_LSB]);
    assign ir_branch = !ir_is_li && is_branch(ir_op);

    assign rf_we    = (state_reg == ST_WB) && !ir_branch;
    assign rf_waddr = ir_reg[RD_MSB:RD_LSB];
    assign rf_wdata = ir_is_li ? ir_reg[IMM_MSB:IMM_LSB] : alu_f;

    // Taken branches add the signed offset; everything else advances by one (mod 256)
    always_comb begin
        pc_next = pc_reg + 8'd1;
        if (ir_branch && alu_take_branch) begin
            pc_next = pc_reg + sext_off(ir_reg[OFF_MSB:OFF_LSB]);
        end
    end

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .ra_addr  (instr[RA_MSB:RA_LSB]),
        .rb_addr  (instr[RB_MSB:RB_LSB]),
        .dbg_addr (dbg_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ir_reg      <= '0;
            pc_reg      <= '0;
            ovf_reg     <= 1'b0;
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_sel_reg <= OP_ADD;
        end else begin
            if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        ir_reg <= instr;
                        if (in_is_li) begin
                            state_reg <= ST_WB;
                        end else begin
                            state_reg   <= ST_EXEC;
                            alu_a_reg   <= ra_data;
                            alu_b_reg   <= rb_data;
                            alu_sel_reg <= in_op;
                        end
                    end
                end
                ST_EXEC: begin
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    pc_reg    <= pc_next;
                    state_reg <= ST_IDLE;
                    // Placed after the clear so a same-edge set takes priority
                    if (!ir_is_li && ir_op == OP_ADD && alu_ovf) begin
                        ovf_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc       = pc_reg;
    assign ovf_flag = ovf_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_sel  = alu_sel_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized
// instruction streams checked against an architectural model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_f;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic [7:0]  pc;
    logic        ovf_flag;
    logic        ovf_clr = 1'b0;
    logic [1:0]  dbg_addr = 2'd0;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;
    int tmo    = 0;

    // Architectural model state
    int m_rf [4];
    int m_pc;
    bit m_ovf;

    alu_issue_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_sel         (alu_sel),
        .alu_f           (alu_f),
        .alu_ovf         (alu_ovf),
        .alu_take_branch (alu_take_branch),
        .pc              (pc),
        .ovf_flag        (ovf_flag),
        .ovf_clr         (ovf_clr),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        alu_f           = 8'h00;
        alu_ovf         = 1'b0;
        alu_take_branch = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            3'd1: alu_f = alu_a - alu_b;
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 8'd1 : 8'd0;
            3'd6: alu_take_branch = (alu_a == alu_b);
            default: alu_take_branch = (alu_a != alu_b);
        endcase
    end

    function automatic int to_signed8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_pc  = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_apply(input logic [15:0] w);
        int rd, ra, rb, op, a, b, off, s;
        rd  = int'(w[11:10]);
        ra  = int'(w[9:8]);
        rb  = int'(w[7:6]);
        op  = int'(w[14:12]);
        off = int'(w[5:0]);
        if (off > 31) off -= 64;
        a = to_signed8(m_rf[ra]);
        b = to_signed8(m_rf[rb]);
        if (w[15]) begin
            m_rf[rd] = int'(w[7:0]);
            m_pc = (m_pc + 1) & 255;
        end else if (op >= 6) begin
            if ((op == 6) == (a == b)) m_pc = (m_pc + off) & 255;
            else                       m_pc = (m_pc + 1) & 255;
        end else begin
            case (op)
                0: begin
                    s = a + b;
                    if (s > 127 || s < -128) m_ovf = 1;
                end
                1: s = a - b;
                2: s = m_rf[ra] & m_rf[rb];
                3: s = m_rf[ra] | m_rf[rb];
                4: s = m_rf[ra] ^ m_rf[rb];
                default: s = (a < b) ? 1 : 0;
            endcase
            m_rf[rd] = s & 255;
            m_pc = (m_pc + 1) & 255;
        end
    endfunction

    function automatic logic [15:0] mk_alu(input int op, input int rd, input int ra,
                                           input int rb, input int off);
        logic [15:0] w;
        w = {1'b0, 3'(op), 2'(rd), 2'(ra), 2'(rb), 6'(off)};
        return w;
    endfunction

    function automatic logic [15:0] mk_li(input int rd, input int imm);
        logic [15:0] w;
        w = {1'b1, 3'b000, 2'(rd), 2'b00, 8'(imm)};
        return w;
    endfunction

    // Stimulus helpers (called at a falling edge)
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic issue_instr(input logic [15:0] w);
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) tmo++;
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        model_apply(w);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) tmo++;
    endtask

    task automatic run_instr(input logic [15:0] w);
        issue_instr(w);
        wait_idle();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++;
        if (ovf_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_flag); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rf r%0d: got %h expected 00", i, dbg_data);
            end
        end
        $display("test_reset done: pc=%h ready=%b ovf=%b", pc, instr_ready, ovf_flag);
    endtask

    task automatic test_overflow_add();
        run_instr(mk_li(1, 8'h70));
        run_instr(mk_li(2, 8'h20));
        issue_instr(mk_alu(0, 3, 1, 2, 0));
        checks++;
        if (alu_a !== 8'h70 || alu_b !== 8'h20 || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL exec_operands: got a=%h b=%h sel=%b expected a=70 b=20 sel=000", alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        checks++;
        if (alu_a !== 8'h70 || alu_b !== 8'h20 || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL wb_operands_held: got a=%h b=%h sel=%b expected a=70 b=20 sel=000", alu_a, alu_b, alu_sel);
        end
        wait_idle();
        dbg_addr = 2'd3;
        #1;
        checks++;
        if (dbg_data !== 8'h90) begin errors++; $display("FAIL add_r3: got %h expected 90", dbg_data); end
        checks++;
        if (ovf_flag !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b expected 1", ovf_flag); end
        checks++;
        if (pc !== 8'h03) begin errors++; $display("FAIL add_pc: got %h expected 03", pc); end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL overflow_timeout: got %0d expected 0", tmo); tmo = 0; end
        $display("test_overflow_add: r3=%h ovf=%b pc=%h", dbg_data, ovf_flag, pc);
    endtask

    task automatic test_branch();
        run_instr(mk_alu(6, 0, 1, 1, -2));
        checks++;
        if (pc !== 8'h01) begin errors++; $display("FAIL beq_taken_pc: got %h expected 01", pc); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 8'(m_rf[i])) begin
                errors++;
                $display("FAIL branch_no_write r%0d: got %h expected %h", i, dbg_data, 8'(m_rf[i]));
            end
        end
        @(negedge clk);
        run_instr(mk_alu(6, 0, 1, 1, -1));
        checks++;
        if (pc !== 8'h00) begin errors++; $display("FAIL beq_to_zero_pc: got %h expected 00", pc); end
        run_instr(mk_alu(6, 2, 1, 1, -1));
        checks++;
        if (pc !== 8'hFF) begin errors++; $display("FAIL beq_wrap_pc: got %h expected FF", pc); end
        run_instr(mk_alu(6, 0, 2, 2, 17));
        checks++;
        if (pc !== 8'h10) begin errors++; $display("FAIL beq_fwd_wrap_pc: got %h expected 10", pc); end
        run_instr(mk_alu(7, 0, 1, 1, 5));
        checks++;
        if (pc !== 8'h11) begin errors++; $display("FAIL bne_not_taken_pc: got %h expected 11", pc); end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL branch_timeout: got %0d expected 0", tmo); tmo = 0; end
        $display("test_branch: final pc=%h", pc);
    endtask

    task automatic test_back_to_back();
        logic [15:0] list [16];
        int acc [16];
        int idx = 0;
        int n   = 0;
        logic rdy;
        for (int i = 0; i < 16; i++) begin
            list[i] = 16'($urandom);
            if (i % 3 == 0) list[i][15] = 1'b1;
        end
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = list[0];
        while (idx < 16 && n < 200) begin
            rdy = instr_ready;
            @(posedge clk);
            n++;
            if (rdy) begin
                acc[idx] = n;
                model_apply(list[idx]);
                idx++;
            end
            @(negedge clk);
            if (idx < 16) instr = list[idx];
            else          instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        checks++;
        if (idx != 16) begin errors++; $display("FAIL b2b_accept_count: got %0d expected 16", idx); end
        for (int k = 0; k < 15; k++) begin
            if (k + 1 < idx) begin
                checks++;
                if (acc[k+1] - acc[k] != (list[k][15] ? 2 : 3)) begin
                    errors++;
                    $display("FAIL b2b_interval[%0d]: got %0d expected %0d", k, acc[k+1] - acc[k], list[k][15] ? 2 : 3);
                end
            end
        end
        wait_idle();
        checks++;
        if (pc !== 8'(m_pc)) begin errors++; $display("FAIL b2b_pc: got %h expected %h", pc, 8'(m_pc)); end
        checks++;
        if (ovf_flag !== m_ovf) begin errors++; $display("FAIL b2b_ovf: got %b expected %b", ovf_flag, m_ovf); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 8'(m_rf[i])) begin
                errors++;
                $display("FAIL b2b_rf r%0d: got %h expected %h", i, dbg_data, 8'(m_rf[i]));
            end
        end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL b2b_timeout: got %0d expected 0", tmo); tmo = 0; end
        $display("test_back_to_back: %0d accepts in %0d cycles, pc=%h", idx, n, pc);
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                ovf_clr = 1'b1;
                @(negedge clk);
                ovf_clr = 1'b0;
                m_ovf = 0;
            end
            w = 16'($urandom);
            run_instr(w);
            checks++;
            if (pc !== 8'(m_pc)) begin errors++; $display("FAIL rand_pc[%0d] w=%h: got %h expected %h", t, w, pc, 8'(m_pc)); end
            checks++;
            if (ovf_flag !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d] w=%h: got %b expected %b", t, w, ovf_flag, m_ovf); end
            for (int i = 0; i < 4; i++) begin
                dbg_addr = 2'(i);
                #0.5;
                checks++;
                if (dbg_data !== 8'(m_rf[i])) begin
                    errors++;
                    $display("FAIL rand_rf[%0d] r%0d w=%h: got %h expected %h", t, i, w, dbg_data, 8'(m_rf[i]));
                end
            end
            $display("rand[%0d] w=%h pc=%h ovf=%b", t, w, pc, ovf_flag);
        end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL rand_timeout: got %0d expected 0", tmo); tmo = 0; end
    endtask

    task automatic test_reset_exec();
        run_instr(mk_li(1, 8'h05));
        run_instr(mk_li(2, 8'h06));
        issue_instr(mk_alu(0, 0, 1, 2, 0));
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 8'h00) begin errors++; $display("FAIL rst_exec_pc_async: got %h expected 00", pc); end
        checks++;
        if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready_async: got %b expected 1", instr_ready); end
        checks++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'b000) begin
            errors++;
            $display("FAIL rst_exec_alu_regs: got a=%h b=%h sel=%b expected 00 00 000", alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        @(negedge clk);
        model_reset();
        dbg_addr = 2'd0;
        #1;
        checks++;
        if (dbg_data !== 8'h00) begin errors++; $display("FAIL rst_exec_r0: got %h expected 00", dbg_data); end
        @(negedge clk);
        // Release reset with an LI already offered: it must be taken on the very next edge
        rst_n       = 1'b1;
        instr_valid = 1'b1;
        instr       = mk_li(2, 8'h33);
        @(posedge clk);
        model_apply(instr);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 8'h01) begin errors++; $display("FAIL first_accept_pc: got %h expected 01", pc); end
        dbg_addr = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 8'h33) begin errors++; $display("FAIL first_accept_r2: got %h expected 33", dbg_data); end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL rst_exec_timeout: got %0d expected 0", tmo); tmo = 0; end
        $display("test_reset_exec: pc=%h r2=%h", pc, dbg_data);
    endtask

    task automatic test_flag_race();
        do_reset();
        run_instr(mk_li(1, 8'h70));
        run_instr(mk_li(2, 8'h20));
        issue_instr(mk_alu(0, 3, 1, 2, 0));
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf_flag !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b expected 1", ovf_flag); end
        checks++;
        if (pc !== 8'h03) begin errors++; $display("FAIL race_pc: got %h expected 03", pc); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf_flag); end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL race_timeout: got %0d expected 0", tmo); tmo = 0; end
        $display("test_flag_race: ovf after clear=%b", ovf_flag);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overflow_add();
        test_branch();
        test_back_to_back();
        test_random();
        test_reset_exec();
        test_flag_race();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
